// File: rtl/dnn_result_readout.sv
// dnn_result_readout: captures a bank of signed class scores when the inference
// engine signals done, scans the bank for the maximum score (argmax) one class
// per cycle, and serves registered indexed reads of the captured bank.
// Optional feature macro: READOUT_IDX_ERR_EN adds an rd_err output that flags
// reads with an out-of-range class index (such reads then return zero).
module dnn_result_readout #(
    parameter int DATA_WIDTH  = 11,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cap,
    input  logic                              clear,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores,
    input  logic                              rd_en,
    input  logic [IDX_WIDTH-1:0]              rd_idx,
    output logic [DATA_WIDTH-1:0]             rd_data,
    output logic                              rd_valid,
`ifdef READOUT_IDX_ERR_EN
    output logic                              rd_err,
`endif
    output logic                              busy,
    output logic                              result_valid,
    output logic [IDX_WIDTH-1:0]              class_id,
    output logic [DATA_WIDTH-1:0]             max_score
);

    // Reject parameter sets the index logic cannot represent.
    if (NUM_CLASSES < 2 || NUM_CLASSES > 16 || IDX_WIDTH < $clog2(NUM_CLASSES)) begin : g_bad_params
        $error("dnn_result_readout: illegal NUM_CLASSES/IDX_WIDTH combination");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  bank_q [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0]  bank_d [NUM_CLASSES];
    logic [IDX_WIDTH-1:0]          cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]          class_id_q, class_id_d;
    logic signed [DATA_WIDTH-1:0]  max_score_q, max_score_d;
    logic signed [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                          rd_valid_q, rd_valid_d;
    logic                          busy_q, busy_d;
    logic                          result_valid_q, result_valid_d;
`ifdef READOUT_IDX_ERR_EN
    logic                          rd_err_q, rd_err_d;
`endif

    // Bank entry currently under comparison and bank entry addressed by a read.
    logic signed [DATA_WIDTH-1:0]  scan_val;
    logic signed [DATA_WIDTH-1:0]  rd_sel;
    logic                          rd_oob;

    // Next-state logic: clear beats cap, cap restarts a scan from any state,
    // SCAN walks the bank keeping the lowest index on ties.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        cnt_d       = cnt_q;
        class_id_d  = class_id_q;
        max_score_d = max_score_q;

        scan_val = bank_q[0];
        rd_sel   = bank_q[0];
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cnt_q == IDX_WIDTH'(k))  scan_val = bank_q[k];
            if (rd_idx == IDX_WIDTH'(k)) rd_sel   = bank_q[k];
        end
        rd_oob = (int'(rd_idx) >= NUM_CLASSES);

        if (clear) begin
            for (int k = 0; k < NUM_CLASSES; k++) bank_d[k] = '0;
            cnt_d       = '0;
            class_id_d  = '0;
            max_score_d = '0;
            state_d     = IDLE;
        end else if (cap) begin
            for (int k = 0; k < NUM_CLASSES; k++) bank_d[k] = scores[k*DATA_WIDTH +: DATA_WIDTH];
            cnt_d       = IDX_WIDTH'(1);
            class_id_d  = '0;
            max_score_d = scores[DATA_WIDTH-1:0];
            state_d     = SCAN;
        end else if (state_q == SCAN) begin
            if (scan_val > max_score_q) begin
                max_score_d = scan_val;
                class_id_d  = cnt_q;
            end
            if (cnt_q == LAST_IDX) begin
                cnt_d   = '0;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q + IDX_WIDTH'(1);
            end
        end

        busy_d         = (state_d == SCAN);
        result_valid_d = (state_d == DONE);

        // Reads see the bank as it was before this edge, so a read issued
        // together with cap returns the pre-capture value.
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
`ifdef READOUT_IDX_ERR_EN
        rd_err_d = rd_en & rd_oob;
        if (rd_en) rd_data_d = rd_oob ? '0 : rd_sel;
`else
        if (rd_en) rd_data_d = rd_oob ? bank_q[0] : rd_sel;
`endif
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            for (int k = 0; k < NUM_CLASSES; k++) bank_q[k] <= '0;
            cnt_q          <= '0;
            class_id_q     <= '0;
            max_score_q    <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef READOUT_IDX_ERR_EN
            rd_err_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            bank_q         <= bank_d;
            cnt_q          <= cnt_d;
            class_id_q     <= class_id_d;
            max_score_q    <= max_score_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
`ifdef READOUT_IDX_ERR_EN
            rd_err_q       <= rd_err_d;
`endif
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign class_id     = class_id_q;
    assign max_score    = max_score_q;
`ifdef READOUT_IDX_ERR_EN
    assign rd_err       = rd_err_q;
`endif

endmodule

// File: tb/tb_dnn_result_readout.sv
// Testbench for dnn_result_readout: drives known and random score sets and
// compares argmax results, timing and readback against a behavioural model.
module tb_dnn_result_readout;
    localparam int DW = 11;
    localparam int NC = 10;
    localparam int IW = 4;

    typedef logic signed [DW-1:0] score_t;

    logic              clk = 1'b0;
    logic              rst, cap, clear, rd_en;
    logic [NC*DW-1:0]  scores;
    logic [IW-1:0]     rd_idx;
    logic [DW-1:0]     rd_data;
    logic              rd_valid, busy, result_valid;
    logic [IW-1:0]     class_id;
    logic [DW-1:0]     max_score;
`ifdef READOUT_IDX_ERR_EN
    logic              rd_err;
`endif

    int checks = 0;
    int errors = 0;

    score_t sc   [NC];   // scores being presented
    score_t mdl  [NC];   // model of the captured bank

    dnn_result_readout #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .cap(cap), .clear(clear), .scores(scores),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
`ifdef READOUT_IDX_ERR_EN
        .rd_err(rd_err),
`endif
        .busy(busy), .result_valid(result_valid), .class_id(class_id), .max_score(max_score)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_scores();
        for (int k = 0; k < NC; k++) scores[k*DW +: DW] = sc[k];
    endtask

    // Reference argmax: first index holding the largest signed value.
    function automatic int model_argmax();
        int best = 0;
        for (int k = 1; k < NC; k++) if (mdl[k] > mdl[best]) best = k;
        return best;
    endfunction

    task automatic rand_scores(input bit narrow);
        for (int k = 0; k < NC; k++) begin
            if (narrow) sc[k] = score_t'($urandom_range(6) - 3);
            else        sc[k] = score_t'($urandom);
        end
    endtask

    task automatic do_cap();
        drive_scores();
        cap = 1'b1;
        tick();
        cap = 1'b0;
        mdl = sc;
    endtask

    task automatic test_reset();
        rst = 1'b0; cap = 1'b0; clear = 1'b0; rd_en = 1'b0; rd_idx = '0; scores = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%0b rv=%0b want 0 0", busy, result_valid); end
        checks++; if (class_id !== '0 || max_score !== '0) begin errors++; $display("FAIL reset_result got id=%0d max=%0d want 0 0", class_id, max_score); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL reset_read got vld=%0b data=%0d want 0 0", rd_valid, rd_data); end
        rst = 1'b1;
        for (int k = 0; k < NC; k++) mdl[k] = '0;
        tick(); tick();
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%0b rv=%0b want 0 0", busy, result_valid); end
    endtask

    task automatic test_known();
        int v [NC] = '{5, -3, 12, 7, 0, 1, 2, 3, 4, -1};
        for (int k = 0; k < NC; k++) sc[k] = score_t'(v[k]);
        do_cap();
        for (int c = 1; c < NC; c++) begin
            checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL known_busy cycle %0d got busy=%0b rv=%0b want 1 0", c, busy, result_valid); end
            tick();
        end
        checks++; if (busy !== 1'b0 || result_valid !== 1'b1) begin errors++; $display("FAIL known_done got busy=%0b rv=%0b want 0 1", busy, result_valid); end
        checks++; if (class_id !== IW'(2) || $signed(max_score) !== 12) begin errors++; $display("FAIL known_result got id=%0d max=%0d want 2 12", class_id, $signed(max_score)); end
    endtask

    task automatic test_ties();
        for (int k = 0; k < NC; k++) sc[k] = score_t'(-4);
        sc[6] = score_t'(-1);
        do_cap();
        repeat (NC - 1) tick();
        checks++; if (result_valid !== 1'b1 || class_id !== IW'(6) || $signed(max_score) !== -1) begin errors++; $display("FAIL tie_run1 got rv=%0b id=%0d max=%0d want 1 6 -1", result_valid, class_id, $signed(max_score)); end
        for (int k = 0; k < NC; k++) sc[k] = score_t'($urandom_range(28) - 20);
        sc[3] = score_t'(9);
        sc[8] = score_t'(9);
        do_cap();
        repeat (NC - 1) tick();
        checks++; if (result_valid !== 1'b1 || class_id !== IW'(3) || $signed(max_score) !== 9) begin errors++; $display("FAIL tie_run2 got rv=%0b id=%0d max=%0d want 1 3 9", result_valid, class_id, $signed(max_score)); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int b;
            rand_scores(r[0]);
            do_cap();
            repeat (NC - 1) tick();
            b = model_argmax();
            checks++; if (result_valid !== 1'b1 || class_id !== IW'(b) || max_score !== mdl[b]) begin errors++; $display("FAIL random_run%0d got rv=%0b id=%0d max=%0d want 1 %0d %0d", r, result_valid, class_id, $signed(max_score), b, mdl[b]); end
            repeat (3) tick();
            checks++; if (result_valid !== 1'b1 || class_id !== IW'(b) || max_score !== mdl[b]) begin errors++; $display("FAIL random_hold%0d got rv=%0b id=%0d max=%0d want 1 %0d %0d", r, result_valid, class_id, $signed(max_score), b, mdl[b]); end
        end
    endtask

    task automatic test_readback();
        for (int i = 0; i <= NC; i++) begin
            rd_en  = (i < NC);
            rd_idx = IW'(i % NC);
            tick();
            if (i < NC) begin
                checks++; if (rd_valid !== 1'b1 || rd_data !== mdl[i]) begin errors++; $display("FAIL read_idx%0d got vld=%0b data=%0d want 1 %0d", i, rd_valid, $signed(rd_data), mdl[i]); end
            end else begin
                checks++; if (rd_valid !== 1'b0 || rd_data !== mdl[NC-1]) begin errors++; $display("FAIL read_hold got vld=%0b data=%0d want 0 %0d", rd_valid, $signed(rd_data), mdl[NC-1]); end
            end
        end
        rd_en = 1'b1; rd_idx = IW'(12);
        tick();
        rd_en = 1'b0;
`ifdef READOUT_IDX_ERR_EN
        checks++; if (rd_valid !== 1'b1 || rd_data !== '0 || rd_err !== 1'b1) begin errors++; $display("FAIL read_oob got vld=%0b data=%0d err=%0b want 1 0 1", rd_valid, $signed(rd_data), rd_err); end
`else
        checks++; if (rd_valid !== 1'b1 || rd_data !== mdl[0]) begin errors++; $display("FAIL read_oob got vld=%0b data=%0d want 1 %0d", rd_valid, $signed(rd_data), mdl[0]); end
`endif
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL read_idle got vld=%0b want 0", rd_valid); end
    endtask

    task automatic test_read_during_cap();
        score_t old [NC];
        int k, b;
        old = mdl;
        k = $urandom_range(NC - 1, 1);
        rand_scores(1'b0);
        sc[k] = ~old[k];
        drive_scores();
        cap = 1'b1; rd_en = 1'b1; rd_idx = IW'(k);
        tick();
        cap = 1'b0; rd_en = 1'b0;
        mdl = sc;
        checks++; if (rd_valid !== 1'b1 || rd_data !== old[k] || busy !== 1'b1) begin errors++; $display("FAIL read_with_cap got vld=%0b data=%0d busy=%0b want 1 %0d 1", rd_valid, $signed(rd_data), busy, old[k]); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== mdl[k]) begin errors++; $display("FAIL read_after_cap got data=%0d want %0d", $signed(rd_data), mdl[k]); end
        repeat (NC - 2) tick();
        b = model_argmax();
        checks++; if (result_valid !== 1'b1 || class_id !== IW'(b)) begin errors++; $display("FAIL read_cap_result got rv=%0b id=%0d want 1 %0d", result_valid, class_id, b); end
    endtask

    task automatic test_recap();
        int b;
        rand_scores(1'b0);
        do_cap();
        repeat (3) tick();
        rand_scores(1'b0);
        do_cap();
        for (int c = 5; c < 14; c++) begin
            checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL recap_busy cycle %0d got busy=%0b rv=%0b want 1 0", c, busy, result_valid); end
            tick();
        end
        b = model_argmax();
        checks++; if (result_valid !== 1'b1 || class_id !== IW'(b) || max_score !== mdl[b]) begin errors++; $display("FAIL recap_result got rv=%0b id=%0d max=%0d want 1 %0d %0d", result_valid, class_id, $signed(max_score), b, mdl[b]); end
    endtask

    task automatic test_clear_cap();
        rand_scores(1'b0);
        sc[0] = score_t'(77);
        drive_scores();
        clear = 1'b1; cap = 1'b1;
        tick();
        clear = 1'b0; cap = 1'b0;
        for (int k = 0; k < NC; k++) mdl[k] = '0;
        tick();
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || class_id !== '0 || max_score !== '0) begin errors++; $display("FAIL clear_cap got busy=%0b rv=%0b id=%0d max=%0d want 0 0 0 0", busy, result_valid, class_id, $signed(max_score)); end
        rd_en = 1'b1; rd_idx = '0;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== mdl[0]) begin errors++; $display("FAIL clear_bank got vld=%0b data=%0d want 1 0", rd_valid, $signed(rd_data)); end
    endtask

    task automatic test_async_reset();
        rand_scores(1'b0);
        sc[0] = score_t'(100);
        do_cap();
        rd_en = 1'b1; rd_idx = '0;
        repeat (4) tick();
        rd_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || class_id !== '0 || max_score !== '0) begin errors++; $display("FAIL async_rst_result got busy=%0b rv=%0b id=%0d max=%0d want 0 0 0 0", busy, result_valid, class_id, $signed(max_score)); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== '0) begin errors++; $display("FAIL async_rst_read got vld=%0b data=%0d want 0 0", rd_valid, $signed(rd_data)); end
        tick();
        rst = 1'b1;
        for (int k = 0; k < NC; k++) mdl[k] = '0;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL post_rst cycle %0d got busy=%0b rv=%0b want 0 0", c, busy, result_valid); end
        end
        rd_en = 1'b1; rd_idx = '0;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== mdl[0]) begin errors++; $display("FAIL post_rst_bank got data=%0d want 0", $signed(rd_data)); end
    endtask

    initial begin
        test_reset();
        test_known();
        test_ties();
        test_random();
        test_readback();
        test_read_during_cap();
        test_recap();
        test_clear_cap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
